tick_gen_multi: RTL

- Multi-channel, runtime-programmable tick generator. Next generation of the single fixed-rate 1-cycle tick source.
- Each of NUM_CH channels has its own period, periodic/one-shot mode and enable.
- All channels share clk100Mhz. A global sync clear phase-aligns every channel at once.
- Feeds scan timers, debouncers and IR-remote bit timing. Consumers use tick[i] as a clock enable.

---
 rtl/tick_pkg.sv | 14 +
 rtl/tick_channel.sv | 68 ++++++
 rtl/tick_gen_multi.sv | 54 +++++
 3 files changed

// File: rtl/tick_pkg.sv
// tick_pkg: shared constants, mode encoding and parameter helpers for the tick generator
package tick_pkg;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam int CLK_FREQ_DEF = 100_000_000;
  localparam int TICK_FREQ_DEF = 1000;
  localparam int DEF_PERIOD = CLK_FREQ_DEF / TICK_FREQ_DEF - 1;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic longint def_period(input longint clk_hz, input longint tick_hz);
    return clk_hz / tick_hz - 1;
  endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one programmable tick counter with periodic/one-shot mode and busy flag
module tick_channel
  import tick_pkg::*;
#(
  parameter int CNT_W = 27,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD)
) (
  input  logic             clk100Mhz,
  input  logic             rstn,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             oneshot_i,
  input  logic             en_i,
  input  logic             sync_clr_i,
  output logic             tick_o,
  output logic             busy_o
);
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic mode_q, mode_d, done_q, done_d, tick_q, tick_d, busy_q, busy_d;
  // next state: sync_clr beats a config write, which beats disable, which beats counting
  always_comb begin
    period_d = period_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    done_d = done_q;
    tick_d = 1'b0;
    if (sync_clr_i || !en_i) begin
      cnt_d = '0;
      done_d = 1'b0;
    end else if (wr_i) begin
      period_d = period_i;
      mode_d = oneshot_i;
      cnt_d = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      tick_d = cnt_q == period_q;
      cnt_d = tick_d ? '0 : cnt_q + 1'b1;
      done_d = tick_d && mode_q == MODE_ONESHOT;
    end
    if (wr_i && !sync_clr_i) begin
      period_d = period_i;
      mode_d = oneshot_i;
      cnt_d = '0;
      done_d = 1'b0;
    end
    busy_d = en_i & ~done_d;
  end
  // channel state and registered outputs, async reset to the default rate
  always_ff @(posedge clk100Mhz or negedge rstn) begin
    if (!rstn) begin
      period_q <= RST_PERIOD;
      mode_q <= MODE_PERIODIC;
      cnt_q <= '0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      period_q <= period_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
    end
  end
  assign tick_o = tick_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH runtime-programmable tick channels with shared config port and sync clear
module tick_gen_multi
  import tick_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int DEF_TICK_FREQ = TICK_FREQ_DEF,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 27,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk100Mhz,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy,
  output logic              cfg_err
);
  localparam longint RST_P = def_period(CLK_FREQ, DEF_TICK_FREQ);
  if (NUM_CH < 1) begin : g_bad_ch
    $error("NUM_CH must be at least 1");
  end
  if ((RST_P >> CNT_W) != 0) begin : g_bad_w
    $error("CNT_W too narrow for the default period");
  end
  logic cfg_err_q, cfg_err_d;
  assign cfg_err_d = cfg_we & (sync_clr | (int'(cfg_ch) >= NUM_CH));
  // a write is rejected when it collides with sync_clr or targets a missing channel
  always_ff @(posedge clk100Mhz or negedge rstn) begin
    if (!rstn) cfg_err_q <= 1'b0;
    else cfg_err_q <= cfg_err_d;
  end
  assign cfg_err = cfg_err_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W(CNT_W),
      .RST_PERIOD(CNT_W'(RST_P))
    ) u_ch (
      .clk100Mhz(clk100Mhz),
      .rstn(rstn),
      .wr_i(cfg_we && cfg_ch == CH_W'(i)),
      .period_i(cfg_period),
      .oneshot_i(cfg_oneshot),
      .en_i(ch_en[i]),
      .sync_clr_i(sync_clr),
      .tick_o(tick[i]),
      .busy_o(busy[i])
    );
  end
endmodule
